amiq_fifo_sync_rd: RTL and testbench



---
 rtl/amiq_fifo_pkg.sv | 22 ++
 rtl/amiq_fifo_mem.sv | 30 +++
 rtl/amiq_fifo_sync_rd.sv | 123 ++++++++++++
 tb/tb_amiq_fifo_sync_rd.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/amiq_fifo_pkg.sv
// Shared types and defaults for the amiq synchronous FIFO family.
//   level_w()  : width of an occupancy counter able to hold 0..depth
//   rd_mode_t  : read-side behaviour (registered read or first-word-fall-through)
//   DEF_*      : default geometry and threshold values
package amiq_fifo_pkg;

    typedef enum logic {
        AMIQ_FIFO_STD  = 1'b0,
        AMIQ_FIFO_FWFT = 1'b1
    } rd_mode_t;

    localparam int DEF_M         = 8;
    localparam int DEF_DEPTH     = 16;
    localparam int DEF_AE_THRESH = 2;
    localparam int DEF_AF_THRESH = 14;

    // Occupancy runs 0..depth inclusive, so one more code than the pointers.
    function automatic int level_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/amiq_fifo_mem.sv
// 1W1R storage array, DEPTH x M.
//   clk      : write clock
//   wr_en    : write strobe (already qualified by the caller)
//   wr_addr  : write address
//   wr_data  : write data
//   rd_addr  : read address
//   rd_data  : combinational read of the addressed entry
// Contents are deliberately not reset.
module amiq_fifo_mem #(
    parameter int M     = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [M-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [M-1:0]  rd_data
);

    logic [M-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/amiq_fifo_sync_rd.sv
// Single-clock FIFO with selectable read mode.
//   clk, rst          : clock, synchronous active-high reset
//   wr_en, wr_data    : write request / data
//   full, almost_full : level == DEPTH, level >= AF_THRESH
//   overflow          : one-cycle pulse after a wr_en seen while full
//   rd_en             : read request
//   rd_data, rd_valid : read data and its qualifier (timing depends on FWFT)
//   empty, almost_empty : level == 0, level <= AE_THRESH
//   underflow         : one-cycle pulse after an rd_en seen while empty
//   level             : current occupancy
module amiq_fifo_sync_rd
    import amiq_fifo_pkg::*;
#(
    parameter int M         = DEF_M,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int FWFT      = 0,
    parameter int AE_THRESH = DEF_AE_THRESH,
    parameter int AF_THRESH = DEF_AF_THRESH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [M-1:0]              wr_data,
    output logic                      full,
    output logic                      almost_full,
    output logic                      overflow,
    input  logic                      rd_en,
    output logic [M-1:0]              rd_data,
    output logic                      rd_valid,
    output logic                      empty,
    output logic                      almost_empty,
    output logic                      underflow,
    output logic [level_w(DEPTH)-1:0] level
);

    localparam int       AW   = $clog2(DEPTH);
    localparam int       LW   = level_w(DEPTH);
    localparam rd_mode_t MODE = (FWFT != 0) ? AMIQ_FIFO_FWFT : AMIQ_FIFO_STD;

    localparam logic [LW-1:0] AE_L    = LW'(AE_THRESH);
    localparam logic [LW-1:0] AF_L    = LW'(AF_THRESH);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level_nxt;
    logic [M-1:0]  mem_rd;
    logic          wr_acc, rd_acc;

    // Accept decisions use the registered flags, so a read when full and a
    // write when empty are both still accepted alongside the rejected one.
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    amiq_fifo_mem #(.M(M), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_addr (rd_ptr),
        .rd_data (mem_rd)
    );

    always_comb begin
        level_nxt = level;
        case ({wr_acc, rd_acc})
            2'b10:   level_nxt = level + LW'(1);
            2'b01:   level_nxt = level - LW'(1);
            default: level_nxt = level;
        endcase
    end

    // Flags are registered from level_nxt so they line up with level itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= (AF_THRESH == 0);
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
            level        <= level_nxt;
            empty        <= (level_nxt == '0);
            full         <= (level_nxt == DEPTH_L);
            almost_empty <= (level_nxt <= AE_L);
            almost_full  <= (level_nxt >= AF_L);
            overflow     <= wr_en && full;
            underflow    <= rd_en && empty;
        end
    end

    generate
        if (MODE == AMIQ_FIFO_STD) begin : g_std
            logic [M-1:0] rd_data_q;
            logic         rd_valid_q;

            // Data register only loads on a pop, so it holds between reads.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) rd_data_q <= mem_rd;
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end else begin : g_fwft
            // Head entry is shown directly; forced to zero while empty so the
            // un-reset storage never leaks onto the port.
            assign rd_data  = empty ? '0 : mem_rd;
            assign rd_valid = !empty;
        end
    endgenerate

endmodule

// File: tb/tb_amiq_fifo_sync_rd.sv
module tb_amiq_fifo_sync_rd;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Standard-mode DUT, DEPTH=4, AE=1, AF=3
    logic       s_rst = 1'b0, s_wr = 1'b0, s_rd = 1'b0;
    logic [7:0] s_wd = '0, s_rdd;
    logic       s_full, s_af, s_ov, s_rv, s_empty, s_ae, s_un;
    logic [2:0] s_lvl;

    // FWFT-mode DUT, same geometry
    logic       f_rst = 1'b0, f_wr = 1'b0, f_rd = 1'b0;
    logic [7:0] f_wd = '0, f_rdd;
    logic       f_full, f_af, f_ov, f_rv, f_empty, f_ae, f_un;
    logic [2:0] f_lvl;

    amiq_fifo_sync_rd #(.M(8), .DEPTH(4), .FWFT(0), .AE_THRESH(1), .AF_THRESH(3)) u_std (
        .clk(clk), .rst(s_rst), .wr_en(s_wr), .wr_data(s_wd), .full(s_full),
        .almost_full(s_af), .overflow(s_ov), .rd_en(s_rd), .rd_data(s_rdd),
        .rd_valid(s_rv), .empty(s_empty), .almost_empty(s_ae), .underflow(s_un),
        .level(s_lvl)
    );

    amiq_fifo_sync_rd #(.M(8), .DEPTH(4), .FWFT(1), .AE_THRESH(1), .AF_THRESH(3)) u_fwft (
        .clk(clk), .rst(f_rst), .wr_en(f_wr), .wr_data(f_wd), .full(f_full),
        .almost_full(f_af), .overflow(f_ov), .rd_en(f_rd), .rd_data(f_rdd),
        .rd_valid(f_rv), .empty(f_empty), .almost_empty(f_ae), .underflow(f_un),
        .level(f_lvl)
    );

    typedef struct {
        logic       rst, wr, rd;
        logic [7:0] wd;
        logic [2:0] lvl;
        logic       e, f, af, ae, ov, un, rv;
        logic [7:0] rdd;
    } vec_t;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, wr, rd, input logic [7:0] wd,
                                input logic [2:0] lvl, input logic e, f, af, ae, ov, un, rv,
                                input logic [7:0] rdd);
        vec_t v;
        v.rst = rst; v.wr = wr; v.rd = rd; v.wd = wd; v.lvl = lvl;
        v.e = e; v.f = f; v.af = af; v.ae = ae; v.ov = ov; v.un = un; v.rv = rv; v.rdd = rdd;
        return v;
    endfunction

    // Drive standard DUT at negedge, sample 1 time unit after the rising edge.
    task automatic s_cyc(input logic rst, wr, rd, input logic [7:0] wd);
        @(negedge clk);
        s_rst = rst; s_wr = wr; s_rd = rd; s_wd = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic f_cyc(input logic rst, wr, rd, input logic [7:0] wd);
        @(negedge clk);
        f_rst = rst; f_wr = wr; f_rd = rd; f_wd = wd;
        @(posedge clk);
        #1;
    endtask

    vec_t tv[19];

    initial begin
        // rst wr rd wd   | lvl e f af ae ov un rv rdd
        tv[0]  = mk(1,0,0,8'h00, 0,1,0,0,1,0,0,0,8'h00);
        tv[1]  = mk(0,1,0,8'h11, 1,0,0,0,1,0,0,0,8'h00);
        tv[2]  = mk(0,1,0,8'h22, 2,0,0,0,0,0,0,0,8'h00);
        tv[3]  = mk(0,1,0,8'h33, 3,0,0,1,0,0,0,0,8'h00);
        tv[4]  = mk(0,1,0,8'h44, 4,0,1,1,0,0,0,0,8'h00);
        tv[5]  = mk(0,1,1,8'h55, 3,0,0,1,0,1,0,1,8'h11); // full: pop, write rejected
        tv[6]  = mk(0,0,0,8'h00, 3,0,0,1,0,0,0,0,8'h11); // overflow is a single pulse
        tv[7]  = mk(0,0,1,8'h00, 2,0,0,0,0,0,0,1,8'h22);
        tv[8]  = mk(0,0,1,8'h00, 1,0,0,0,1,0,0,1,8'h33);
        tv[9]  = mk(0,0,1,8'h00, 0,1,0,0,1,0,0,1,8'h44);
        tv[10] = mk(0,1,1,8'hA5, 1,0,0,0,1,0,1,0,8'h44); // empty: write in, read rejected
        tv[11] = mk(0,0,1,8'h00, 0,1,0,0,1,0,0,1,8'hA5);
        tv[12] = mk(0,0,1,8'h00, 0,1,0,0,1,0,1,0,8'hA5);
        tv[13] = mk(0,0,0,8'h00, 0,1,0,0,1,0,0,0,8'hA5);
        tv[14] = mk(0,1,0,8'h01, 1,0,0,0,1,0,0,0,8'hA5);
        tv[15] = mk(0,1,0,8'h02, 2,0,0,0,0,0,0,0,8'hA5);
        tv[16] = mk(0,1,0,8'h03, 3,0,0,1,0,0,0,0,8'hA5);
        tv[17] = mk(1,1,1,8'h04, 0,1,0,0,1,0,0,0,8'h00); // reset wins over wr/rd
        tv[18] = mk(0,0,0,8'h00, 0,1,0,0,1,0,0,0,8'h00);

        for (int i = 0; i < 19; i++) begin
            s_cyc(tv[i].rst, tv[i].wr, tv[i].rd, tv[i].wd);
            chk($sformatf("v%0d level", i),     32'(s_lvl),   32'(tv[i].lvl));
            chk($sformatf("v%0d flags", i),
                32'({s_empty, s_full, s_af, s_ae, s_ov, s_un}),
                32'({tv[i].e, tv[i].f, tv[i].af, tv[i].ae, tv[i].ov, tv[i].un}));
            chk($sformatf("v%0d rd_valid", i),  32'(s_rv),    32'(tv[i].rv));
            chk($sformatf("v%0d rd_data", i),   32'(s_rdd),   32'(tv[i].rdd));
        end

        // Wrap: 10 entries through a depth-4 FIFO, level held around 2.
        begin
            logic [7:0] got[$];
            int         err_pulses = 0;
            s_cyc(1'b0, 1'b1, 1'b0, 8'h00);
            s_cyc(1'b0, 1'b1, 1'b0, 8'h01);
            for (int i = 2; i < 12; i++) begin
                s_cyc(1'b0, (i < 10), 1'b1, 8'(i));
                if (s_rv) got.push_back(s_rdd);
                if (s_ov || s_un) err_pulses++;
            end
            s_cyc(1'b0, 1'b0, 1'b0, 8'h00);
            if (s_rv) got.push_back(s_rdd);
            if (s_ov || s_un) err_pulses++;
            chk("wrap count", 32'(got.size()), 32'd10);
            chk("wrap err pulses", 32'(err_pulses), 32'd0);
            for (int i = 0; i < 10; i++) begin
                chk($sformatf("wrap data%0d", i),
                    (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(i));
            end
            chk("wrap empty", 32'(s_empty), 32'd1);
        end

        // FWFT sequences
        f_cyc(1'b1, 1'b0, 1'b0, 8'h00);
        chk("fwft reset rv",    32'(f_rv),    32'd0);
        chk("fwft reset empty", 32'(f_empty), 32'd1);
        chk("fwft reset data",  32'(f_rdd),   32'd0);
        f_cyc(1'b0, 1'b1, 1'b0, 8'h5A);
        chk("fwft wr rv",    32'(f_rv),  32'd1);
        chk("fwft wr data",  32'(f_rdd), 32'h5A);
        chk("fwft wr level", 32'(f_lvl), 32'd1);
        f_cyc(1'b0, 1'b0, 1'b0, 8'h00);
        chk("fwft hold rv",   32'(f_rv),  32'd1);
        chk("fwft hold data", 32'(f_rdd), 32'h5A);
        f_cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("fwft pop rv",    32'(f_rv),    32'd0);
        chk("fwft pop empty", 32'(f_empty), 32'd1);
        f_cyc(1'b0, 1'b1, 1'b0, 8'h6B);
        f_cyc(1'b0, 1'b1, 1'b0, 8'h7C);
        chk("fwft head2", 32'(f_rdd), 32'h6B);
        f_cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("fwft next rv",   32'(f_rv),  32'd1);
        chk("fwft next data", 32'(f_rdd), 32'h7C);
        chk("fwft next lvl",  32'(f_lvl), 32'd1);
        f_cyc(1'b0, 1'b0, 1'b1, 8'h00);
        f_cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("fwft underflow", 32'(f_un), 32'd1);
        chk("fwft ovf quiet", 32'(f_ov), 32'd0);
        f_cyc(1'b0, 1'b0, 1'b0, 8'h00);
        chk("fwft underflow clr", 32'(f_un), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
